filter2d_lb: RTL and testbench
==============================

Name: filter2d_lb

Overview:
- Line-buffered successor to the 3x3 SRAM-to-SRAM image filter. Each source pixel is read exactly once. Two internal line buffers hold the previous rows, so the block runs at 2 cycles/pixel instead of 12.
- Parametrised in image size, pixel/coefficient width and fixed-point fraction. Border handling (zero-pad or replicate) is selected at runtime.
- Sits between the control FSM (start/finish) and a single-port SRAM: source image at addr 0, result at IMG_W*IMG_H.

Parameters:
- IMG_W, 256, image width in pixels (>=3)
- IMG_H, 256, image height in pixels (>=3)
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width
- FRAC, 4, coefficient fraction bits (0..COEF_W-2)
- ADDR_W, clog2(2*IMG_W*IMG_H), SRAM address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a frame
- border_mode  in  1  0 = zero pad, 1 = replicate edge; sampled at start
- busy  out  1  high from the cycle after start until finish
- finish  out  1  one-cycle pulse at frame end
- cs  out  1  SRAM chip select
- we  out  1  SRAM write enable
- addr  out  ADDR_W  SRAM address
- din  out  PIX_W  SRAM write data
- dout  in  PIX_W  SRAM read data, valid 1 cycle after a read
- h_write  in  1  coefficient write strobe
- h_idx  in  4  coefficient index 0..8, raster order of the 3x3 window
- h_data  in  COEF_W  signed coefficient

Behaviour:
- Reset: busy=0, finish=0, cs=0, we=0, addr=0, din=0.
- Kernel reset value is identity: h[4]=1<<FRAC, all other taps 0.
- h_write is accepted only when busy=0. Writes while busy, and writes with h_idx>8, are ignored.
- States: IDLE -> RUN -> DONE -> IDLE.
  - start in IDLE latches border_mode and enters RUN.
  - start outside IDLE is ignored.
- RUN has N+IMG_W+2 slots, where N=IMG_W*IMG_H. Each slot is 2 cycles.
  - Phase 0: if slot s<N, read source pixel s (cs=1, we=0, addr=s); otherwise cs=0.
  - Phase 1: the returned dout is pushed into the line buffers and the window.
  - Phase 1: if s>=IMG_W+2, write output pixel p=s-IMG_W-2 (cs=1, we=1, addr=N+p, din=result).
  - Outputs are written in strict raster order, exactly N writes.
- After the last phase 1 the block enters DONE for one cycle: finish=1 and busy is dropped.
- Frame total from the start cycle is 2*(N+IMG_W+2)+1 cycles.
- Border handling: taps outside the image are
  - 0 in zero mode;
  - the nearest in-image pixel (clamped x/y) in replicate mode.
  - Corner taps clamp both coordinates.
- Arithmetic:
  - acc is signed, PIX_W+COEF_W+4 bits, and is the sum of 9 products (pixel zero-extended to signed).
  - Rounding: add 1<<(FRAC-1) when FRAC>0, then arithmetic shift right by FRAC.
  - Clamp to 0..2^PIX_W-1.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, no further SRAM access. Line-buffer contents are don't-care; a new frame reloads them.

Optional Feature:
- FILTER2D_LB_SATCNT_EN defined:
  - Adds output sat_cnt, 32 bits wide.
  - Counts output pixels whose pre-clamp value fell below 0 or above 2^PIX_W-1.
  - Cleared on start; holds after finish; reset value 0.
- Undefined: no port and no counter logic.

Decomposition:
- filter2d_pkg holds:
  - border-mode constants (BORDER_ZERO, BORDER_REPL);
  - tap-count constant (9);
  - reset-kernel constant function;
  - state encoding (IDLE, RUN, DONE);
  - accumulator-width function.
- One sub-module: filter2d_linebuf.
  - Two IMG_W x PIX_W row delays; outputs the column triple for the current x.
  - One instance.

Test Plan:
- Identity kernel, IMG_W=IMG_H=4, ramp source (pixel=index) -> output addresses 16..31 hold 0..15; finish exactly 45 cycles after start; 16 writes in order.
- All-ones kernel, FRAC=0, zero mode, constant 10 image 4x4 -> corners 40, edges 60, interior 90.
- Same stimulus in replicate mode -> all outputs 90.
- Saturation: FRAC=0, h[4]=127, source 255 -> 255; h[4]=-1 -> 0; with FILTER2D_LB_SATCNT_EN, sat_cnt=16 in both cases.
- Ignored inputs: h_write and start issued while busy -> kernel unchanged, output identical to an undisturbed run, single finish pulse.
- reset_n low during slot 7 -> cs=we=busy=0 in the same cycle; a following start produces a correct full frame.

Source files
------------

// File: rtl/filter2d_lb_pkg.sv
// Shared constants, state encoding and width/kernel helpers for the
// line-buffered 3x3 image filter.
package filter2d_pkg;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;
  localparam int   TAPS        = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int acc_width(input int pix_w, input int coef_w);
    return pix_w + coef_w + 4;
  endfunction

  // Identity kernel: only the centre tap is one in fixed point.
  function automatic int reset_tap(input int idx, input int frac);
    return (idx == 4) ? (1 << frac) : 0;
  endfunction

endpackage

// File: rtl/filter2d_lb_if.sv
// Single-port SRAM bus between the filter (master) and the memory (slave).
interface filter2d_lb_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
);
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  din;
  logic [PIX_W-1:0]  dout;

  modport master (output cs, we, addr, din, input dout);
  modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/filter2d_lb_linebuf.sv
// Two one-row pixel delays; presents the (row-2, row-1, current) column
// triple for the pixel being pushed at column col.
module filter2d_linebuf #(
  parameter int IMG_W = 256,
  parameter int PIX_W = 8,
  parameter int XW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             push,
  input  logic [XW-1:0]    col,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] top,
  output logic [PIX_W-1:0] mid,
  output logic [PIX_W-1:0] bot
);

  logic [PIX_W-1:0] row1 [IMG_W];
  logic [PIX_W-1:0] row2 [IMG_W];

  assign bot = pix;
  assign mid = row1[col];
  assign top = row2[col];

  always_ff @(posedge clk) begin
    if (push) begin
      row1[col] <= pix;
      row2[col] <= row1[col];
    end
  end

endmodule

// File: rtl/filter2d_lb.sv
// Line-buffered 3x3 filter, 2 cycles per pixel, source at 0, result at N.
// Optional FILTER2D_LB_SATCNT_EN adds a saturated-pixel counter (sat_cnt).
//
//   state | meaning
//   IDLE  | waiting for start; coefficient writes accepted
//   RUN   | slot pairs: phase 0 read pixel s, phase 1 push + write s-W-2
//   DONE  | one cycle, finish pulse
module filter2d_lb
  import filter2d_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int FRAC   = 4,
  parameter int ADDR_W = $clog2(2*IMG_W*IMG_H)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     border_mode,
  output logic                     busy,
  output logic                     finish,
  filter2d_lb_if.master            mem,
  input  logic                     h_write,
  input  logic [3:0]               h_idx,
  input  logic signed [COEF_W-1:0] h_data
`ifdef FILTER2D_LB_SATCNT_EN
  ,
  output logic [31:0]              sat_cnt
`endif
);

  localparam int N     = IMG_W * IMG_H;
  localparam int SLOTS = N + IMG_W + 2;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int ACC_W = acc_width(PIX_W, COEF_W);

  localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);
  localparam logic [ADDR_W-1:0] WR_FIRST  = ADDR_W'(IMG_W + 2);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((1 << FRAC) >> 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << PIX_W) - 1);

  state_t                    state, state_nx;
  logic [ADDR_W-1:0]         slot;
  logic                      phase;
  logic                      bmode;
  logic [XW-1:0]             in_x, out_x;
  logic [YW-1:0]             out_y;
  logic signed [COEF_W-1:0]  h [TAPS];
  logic [PIX_W-1:0]          win [3][3];
  logic [PIX_W-1:0]          col_top, col_mid, col_bot;
  logic signed [ACC_W-1:0]   acc, shifted;
  logic [PIX_W-1:0]          pix_out;
  logic                      ovf_lo, ovf_hi;
  logic                      rd_slot, wr_slot, push, wr_en;

  assign rd_slot = (slot < N_A);
  assign wr_slot = (slot >= WR_FIRST);
  assign push    = (state == RUN) && phase;
  assign wr_en   = push && wr_slot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (phase && (slot == LAST_SLOT)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    finish   = (state == DONE);
    mem.cs   = 1'b0;
    mem.we   = 1'b0;
    mem.addr = '0;
    mem.din  = '0;
    if (state == RUN) begin
      if (!phase && rd_slot) begin
        mem.cs   = 1'b1;
        mem.addr = slot;
      end else if (phase && wr_slot) begin
        mem.cs   = 1'b1;
        mem.we   = 1'b1;
        mem.addr = N_A + slot - WR_FIRST;
        mem.din  = pix_out;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot  <= '0;
      phase <= 1'b0;
      bmode <= BORDER_ZERO;
      in_x  <= '0;
      out_x <= '0;
      out_y <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        slot  <= '0;
        phase <= 1'b0;
        bmode <= border_mode;
        in_x  <= '0;
        out_x <= '0;
        out_y <= '0;
      end
    end else if (state == RUN) begin
      phase <= ~phase;
      if (phase) begin
        slot <= slot + ADDR_W'(1);
        in_x <= (in_x == X_LAST) ? '0 : in_x + XW'(1);
        if (wr_slot) begin
          if (out_x == X_LAST) begin
            out_x <= '0;
            out_y <= out_y + YW'(1);
          end else begin
            out_x <= out_x + XW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) h[i] <= COEF_W'(reset_tap(i, FRAC));
    end else if (h_write && !busy && (h_idx < 4'd9)) begin
      h[h_idx] <= h_data;
    end
  end

  filter2d_linebuf #(.IMG_W(IMG_W), .PIX_W(PIX_W), .XW(XW)) u_linebuf (
    .clk  (clk),
    .push (push),
    .col  (in_x),
    .pix  (mem.dout),
    .top  (col_top),
    .mid  (col_mid),
    .bot  (col_bot)
  );

  // Window is a stream shift register; its centre is the pixel being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (push) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= col_top;
      win[1][2] <= col_mid;
      win[2][2] <= col_bot;
    end
  end

  // Out-of-image taps hold wrapped or stale pixels; remap them to the centre
  // row/column (replicate) or force zero.
  always_comb begin
    acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int               rr, cc;
        logic             inb;
        logic [PIX_W-1:0] tap;
        rr  = r;
        cc  = c;
        inb = 1'b1;
        if ((r == 0) && (out_y == '0))    begin rr = 1; inb = 1'b0; end
        if ((r == 2) && (out_y == Y_LAST)) begin rr = 1; inb = 1'b0; end
        if ((c == 0) && (out_x == '0))    begin cc = 1; inb = 1'b0; end
        if ((c == 2) && (out_x == X_LAST)) begin cc = 1; inb = 1'b0; end
        if (!inb && (bmode == BORDER_ZERO)) tap = '0;
        else                                tap = win[rr][cc];
        acc = acc + $signed({{(ACC_W-PIX_W){1'b0}}, tap})
                  * $signed({{(ACC_W-COEF_W){h[r*3+c][COEF_W-1]}}, h[r*3+c]});
      end
    end
    shifted = (acc + RND) >>> FRAC;
    ovf_lo  = shifted[ACC_W-1];
    ovf_hi  = !ovf_lo && (shifted > MAXV);
    if (ovf_lo)      pix_out = '0;
    else if (ovf_hi) pix_out = MAXV[PIX_W-1:0];
    else             pix_out = shifted[PIX_W-1:0];
  end

`ifdef FILTER2D_LB_SATCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        sat_cnt <= '0;
    else if ((state == IDLE) && start)   sat_cnt <= '0;
    else if (wr_en && (ovf_lo || ovf_hi)) sat_cnt <= sat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_filter2d_lb.sv
// Bench for filter2d_lb: two 4x4 instances (FRAC=0 and FRAC=4) share stimulus;
// each SRAM write is checked against a queued expected (addr, data) pair.
module tb_filter2d_lb;

  localparam int W = 4, H = 4, N = 16, PW = 8, CW = 8, AW = 5;

  logic             clk = 1'b0, reset_n = 1'b0, start = 1'b0, border_mode = 1'b0;
  logic             h_write = 1'b0;
  logic [3:0]       h_idx = '0;
  logic signed [7:0] h_data = '0;
  logic             busy0, finish0, busy4, finish4;

  int checks = 0, errors = 0;
  int fin0 = 0, fin4 = 0, wr0 = 0, wr4 = 0;
  int exp_sat0, exp_sat4;
  int kh0 [9], kh4 [9];
  logic [7:0]  src [N];
  logic [7:0]  out0 [N], out4 [N];
  logic [13:0] q0 [$], q4 [$];
  logic [13:0] e0, e4;

  filter2d_lb_if #(.ADDR_W(AW), .PIX_W(PW)) m0 ();
  filter2d_lb_if #(.ADDR_W(AW), .PIX_W(PW)) m4 ();

`ifdef FILTER2D_LB_SATCNT_EN
  logic [31:0] sat0, sat4;
`endif

  filter2d_lb #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CW), .FRAC(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .border_mode(border_mode),
    .busy(busy0), .finish(finish0), .mem(m0),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
`ifdef FILTER2D_LB_SATCNT_EN
    , .sat_cnt(sat0)
`endif
  );

  filter2d_lb #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CW), .FRAC(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .border_mode(border_mode),
    .busy(busy4), .finish(finish4), .mem(m4),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
`ifdef FILTER2D_LB_SATCNT_EN
    , .sat_cnt(sat4)
`endif
  );

  always #5 clk = ~clk;

  // SRAM models: sample the bus mid-cycle, return read data for the next cycle.
  always @(negedge clk) begin
    if (finish0) fin0++;
    if (m0.cs && !m0.we) m0.dout <= src[m0.addr[3:0]];
    if (m0.cs && m0.we) begin
      out0[m0.addr[3:0]] = m0.din;
      wr0++;
      e0 = (q0.size() > 0) ? q0.pop_front() : 14'h0;
      checks++;
      assert ({1'b1, m0.addr, m0.din} === e0) else begin
        errors++;
        $error("FAIL wr_frac0 obs=%h exp=%h", {1'b1, m0.addr, m0.din}, e0);
      end
    end
  end

  always @(negedge clk) begin
    if (finish4) fin4++;
    if (m4.cs && !m4.we) m4.dout <= src[m4.addr[3:0]];
    if (m4.cs && m4.we) begin
      out4[m4.addr[3:0]] = m4.din;
      wr4++;
      e4 = (q4.size() > 0) ? q4.pop_front() : 14'h0;
      checks++;
      assert ({1'b1, m4.addr, m4.din} === e4) else begin
        errors++;
        $error("FAIL wr_frac4 obs=%h exp=%h", {1'b1, m4.addr, m4.din}, e4);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {saturated, pixel}.
  function automatic logic [8:0] model(input int frac, input logic mode, input int x, input int y);
    int acc = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int xx = x + dc, yy = y + dr, v, k;
        bit outside = (xx < 0) || (xx >= W) || (yy < 0) || (yy >= H);
        if (xx < 0) xx = 0;
        if (xx >= W) xx = W - 1;
        if (yy < 0) yy = 0;
        if (yy >= H) yy = H - 1;
        v = (outside && !mode) ? 0 : int'(src[yy*W + xx]);
        k = (frac == 0) ? kh0[(dr+1)*3 + dc + 1] : kh4[(dr+1)*3 + dc + 1];
        acc += v * k;
      end
    end
    if (frac > 0) acc += 1 << (frac - 1);
    acc = acc >>> frac;
    if (acc < 0)   return {1'b1, 8'd0};
    if (acc > 255) return {1'b1, 8'd255};
    return {1'b0, acc[7:0]};
  endfunction

  task automatic set_coef(input int idx, input int val, input bit track);
    h_write = 1'b1;
    h_idx   = idx[3:0];
    h_data  = val[7:0];
    tick();
    h_write = 1'b0;
    if (track && idx < 9) begin
      kh0[idx] = val;
      kh4[idx] = val;
    end
  endtask

  task automatic reset_kernel();
    for (int i = 0; i < 9; i++) begin
      kh0[i] = (i == 4) ? 1 : 0;
      kh4[i] = (i == 4) ? 16 : 0;
    end
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < N; i++)
      case (kind)
        0:       src[i] = 8'(i);
        1:       src[i] = 8'd10;
        2:       src[i] = 8'd255;
        default: src[i] = 8'($urandom_range(0, 255));
      endcase
  endtask

  task automatic push_expected(input logic mode);
    logic [8:0] r;
    exp_sat0 = 0;
    exp_sat4 = 0;
    for (int p = 0; p < N; p++) begin
      r = model(0, mode, p % W, p / W);
      q0.push_back({1'b1, 5'(N + p), r[7:0]});
      exp_sat0 += int'(r[8]);
      r = model(4, mode, p % W, p / W);
      q4.push_back({1'b1, 5'(N + p), r[7:0]});
      exp_sat4 += int'(r[8]);
    end
  endtask

  task automatic run_frame(input logic mode, input bit disturb, input string tag);
    int cnt, f0, f4, w0, w4;
    push_expected(mode);
    f0 = fin0; f4 = fin4; w0 = wr0; w4 = wr4;
    border_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    border_mode = ~mode;
    chk({tag, "_busy_rise"}, {30'd0, busy0, busy4}, 32'd3);
    cnt = 1;
    while (!finish0 && cnt < 200) begin
      if (disturb && cnt == 10) begin
        start = 1'b1; h_write = 1'b1; h_idx = 4'd4; h_data = 8'sd5;
      end else begin
        start = 1'b0; h_write = 1'b0;
      end
      tick();
      cnt++;
    end
    start = 1'b0; h_write = 1'b0;
    chk({tag, "_finish_lat"}, cnt, 45);
    chk({tag, "_finish4"}, {31'd0, finish4}, 32'd1);
    chk({tag, "_busy_fall"}, {30'd0, busy0, busy4}, 32'd0);
    tick(); tick();
    chk({tag, "_fin_pulses"}, (fin0 - f0) * 16 + (fin4 - f4), 17);
    chk({tag, "_writes"}, (wr0 - w0) * 256 + (wr4 - w4), 16 * 256 + 16);
    chk({tag, "_sb_left"}, q0.size() + q4.size(), 0);
`ifdef FILTER2D_LB_SATCNT_EN
    chk({tag, "_sat0"}, sat0, exp_sat0);
    chk({tag, "_sat4"}, sat4, exp_sat4);
`endif
  endtask

  initial begin
    reset_kernel();
    load(0);
    repeat (3) tick();
    chk("rst_busy",   {28'd0, busy0, finish0, busy4, finish4}, 32'd0);
    chk("rst_cs_we",  {28'd0, m0.cs, m0.we, m4.cs, m4.we}, 32'd0);
    chk("rst_addr",   {22'd0, m0.addr, m4.addr}, 32'd0);
    chk("rst_din",    {16'd0, m0.din, m4.din}, 32'd0);
    reset_n = 1'b1;
    tick();
`ifdef FILTER2D_LB_SATCNT_EN
    chk("rst_sat", sat0 | sat4, 32'd0);
`endif

    run_frame(1'b0, 1'b0, "identity");
    chk("identity_px5", {24'd0, out0[5]}, 32'd5);

    set_coef(9, 77, 1'b0);
    for (int i = 0; i < 9; i++) set_coef(i, 1, 1'b1);
    load(1);
    run_frame(1'b0, 1'b0, "ones_zero");
    chk("ones_zero_corner", {24'd0, out0[0]}, 32'd40);
    chk("ones_zero_edge",   {24'd0, out0[1]}, 32'd60);
    chk("ones_zero_inner",  {24'd0, out0[5]}, 32'd90);
    chk("ones_zero_f4",     {24'd0, out4[0]}, 32'd3);
    run_frame(1'b1, 1'b0, "ones_repl");
    chk("ones_repl_corner", {24'd0, out0[15]}, 32'd90);
    chk("ones_repl_edge",   {24'd0, out0[4]},  32'd90);

    for (int i = 0; i < 9; i++) set_coef(i, (i == 4) ? 127 : 0, 1'b1);
    load(2);
    run_frame(1'b0, 1'b0, "sat_hi");
    chk("sat_hi_px", {24'd0, out0[7]}, 32'd255);
    set_coef(4, -1, 1'b1);
    run_frame(1'b1, 1'b0, "sat_lo");
    chk("sat_lo_px", {24'd0, out0[7]}, 32'd0);

    for (int i = 0; i < 9; i++) set_coef(i, int'($urandom_range(0, 40)) - 20, 1'b1);
    load(3);
    run_frame(1'b1, 1'b1, "disturb_repl");
    run_frame(1'b0, 1'b0, "rand_zero");

    load(0);
    push_expected(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("slot7_reading", {30'd0, m0.cs, m0.we}, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("midrst_out", {26'd0, m0.cs, m0.we, busy0, m4.cs, m4.we, busy4}, 32'd0);
    chk("midrst_sb", q0.size(), 15);
    q0.delete();
    q4.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_idle", {30'd0, m0.cs, m4.cs}, 32'd0);
    end
    reset_n = 1'b1;
    reset_kernel();
    tick();
    run_frame(1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
